// File: rtl/crypto_result_drain.sv
// crypto_result_drain: buffers 128-bit crypto results in a DEPTH-entry FIFO and streams them as 32-bit words, MSW first.
// Define CRYPTO_DRAIN_ZEROIZE_EN to scrub entries on pop/reset and blank out_data when idle.
module crypto_result_drain #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     res_valid,
  input  logic [127:0]             res_data,
  output logic                     out_valid,
  output logic [31:0]              out_data,
  output logic                     out_last,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     clr_overflow
);
  localparam int AW = $clog2(DEPTH);
  logic [127:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [1:0] widx;
  logic [127:0] head;
  logic full, xfer, pop, push, drop;
  always_comb begin
    full = level == (AW+1)'(DEPTH);
    out_valid = level != '0;
    xfer = out_valid && out_ready;
    pop = xfer && widx == 2'd3;
    push = res_valid && (!full || pop);
    drop = res_valid && full && !pop;
    head = mem[rp];
    out_last = out_valid && widx == 2'd3;
`ifdef CRYPTO_DRAIN_ZEROIZE_EN
    out_data = out_valid ? head[{~widx, 5'd0} +: 32] : 32'h0;
`else
    out_data = head[{~widx, 5'd0} +: 32];
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      widx <= '0;
      level <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      if (xfer) widx <= widx + 2'd1;
      level <= (push && !pop) ? level + (AW+1)'(1) : (pop && !push) ? level - (AW+1)'(1) : level;
      overflow <= drop ? 1'b1 : clr_overflow ? 1'b0 : overflow;
    end
  end
`ifdef CRYPTO_DRAIN_ZEROIZE_EN
  // push is written after the scrub so a same-entry push wins
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (pop) mem[rp] <= '0;
      if (push) mem[wp] <= res_data;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= res_data;
  end
`endif
endmodule

// File: tb/tb_crypto_result_drain.sv
// tb_crypto_result_drain: scoreboard bench for crypto_result_drain (DEPTH=2).
module tb_crypto_result_drain;
  localparam int DEPTH = 2;
  logic clk = 0, rst = 1, res_valid = 0, out_ready = 0, clr_overflow = 0;
  logic [127:0] res_data = '0;
  logic out_valid, out_last, overflow;
  logic [31:0] out_data;
  logic [1:0] level;
  logic [127:0] b1, ba, bb, bc, bd, be, bx, by;
  logic [32:0] expq [$];
  int errors = 0, checks = 0;

  crypto_result_drain #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .res_valid(res_valid), .res_data(res_data),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .level(level), .overflow(overflow),
    .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %h expected none", out_data);
      end else chk("word", {out_last, out_data}, expq.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic [127:0] d, input bit keep);
    res_valid = 1;
    res_data = d;
    if (keep) for (int i = 3; i >= 0; i--) expq.push_back({i == 0, d[32*i +: 32]});
    tick(1);
    res_valid = 0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (level != 0 && n < 60) begin
      tick(1);
      n++;
    end
    chk("drained_level", level, 0);
    chk("drained_queue", expq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    b1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    ba = 128'hA0A0A0A0_A1A1A1A1_A2A2A2A2_A3A3A3A3;
    bb = 128'hB0B0B0B0_B1B1B1B1_B2B2B2B2_B3B3B3B3;
    bc = 128'hC0C0C0C0_C1C1C1C1_C2C2C2C2_C3C3C3C3;
    bd = 128'hD0D0D0D0_D1D1D1D1_D2D2D2D2_D3D3D3D3;
    be = 128'hE0E0E0E0_E1E1E1E1_E2E2E2E2_E3E3E3E3;
    bx = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;
    by = 128'hCAFEBABE_DEADBEEF_01234567_89ABCDEF;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 0);
    // single block with latency check
    out_ready = 1;
    strobe(b1, 1);
    chk("latency_valid", out_valid, 1);
    chk("latency_word0", out_data, 32'h00112233);
    wait_drain();
    // back-to-back blocks must drain in exactly 8 cycles
    strobe(ba, 1);
    strobe(bb, 1);
    tick(7);
    chk("no_bubble_level", level, 0);
    chk("no_bubble_queue", expq.size(), 0);
    // backpressure
    out_ready = 0;
    strobe(b1, 1);
    repeat (3) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, 32'h00112233);
      chk("bp_last", out_last, 0);
      tick(1);
    end
    out_ready = 1;
    wait_drain();
    // overflow: C dropped, then drop with simultaneous clear keeps overflow set
    out_ready = 0;
    strobe(ba, 1);
    strobe(bb, 1);
    strobe(bc, 0);
    chk("ovf_level", level, 2);
    chk("ovf_set", overflow, 1);
    clr_overflow = 1;
    strobe(bd, 0);
    clr_overflow = 0;
    chk("ovf_set_wins", overflow, 1);
    clr_overflow = 1;
    tick(1);
    clr_overflow = 0;
    chk("ovf_cleared", overflow, 0);
    out_ready = 1;
    wait_drain();
    // full push+pop on the word-3 transfer
    out_ready = 0;
    strobe(ba, 1);
    strobe(bb, 1);
    chk("full_level", level, 2);
    out_ready = 1;
    tick(3);
    chk("full_w3_last", out_last, 1);
    strobe(bc, 1);
    chk("pushpop_level", level, 2);
    chk("pushpop_no_drop", overflow, 0);
    wait_drain();
    // reset after word 1
    out_ready = 0;
    strobe(bd, 1);
    out_ready = 1;
    tick(2);
    out_ready = 0;
    rst = 1;
    tick(1);
    rst = 0;
    expq.delete();
    chk("midrst_valid", out_valid, 0);
    chk("midrst_level", level, 0);
    out_ready = 1;
    strobe(be, 1);
    chk("midrst_word0", out_data, 32'hE0E0E0E0);
    wait_drain();
    // entry contents after a full drain
    rst = 1;
    tick(1);
    rst = 0;
    strobe(bx, 1);
    strobe(by, 1);
    wait_drain();
`ifdef CRYPTO_DRAIN_ZEROIZE_EN
    chk("zero_out_data", out_data, 0);
    chk("zero_mem0", dut.mem[0], 0);
    chk("zero_mem1", dut.mem[1], 0);
`else
    chk("stale_out_data", out_data, bx[127:96]);
    chk("stale_mem0", dut.mem[0], bx);
    chk("stale_mem1", dut.mem[1], by);
`endif
    chk("end_queue", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/crypto_result_drain.md
# crypto_result_drain

Output buffer and serializer directly downstream of the crypto core. It captures each 128-bit result block on the core's one-cycle valid strobe into a small FIFO. It then streams each block out as four 32-bit words over a valid/ready interface, most-significant word first. Blocks that arrive while the buffer is full are dropped and flagged with a sticky overflow bit.

## Interface
- DEPTH, 2, number of 128-bit result entries; power of two, 2..8
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- res_valid  input  1  one-cycle strobe: res_data holds a finished block this cycle
- res_data  input  128  result block from crypto core
- out_valid  output  1  out_data holds a valid word
- out_data  output  32  current word of head block
- out_last  output  1  high with the 4th (final) word of a block
- out_ready  input  1  sink accepts word when high with out_valid
- level  output  $clog2(DEPTH)+1  number of buffered blocks, 0..DEPTH
- overflow  output  1  sticky: a block was dropped
- clr_overflow  input  1  clears overflow

## Operation
- Storage: DEPTH x 128 array, write pointer wp, read pointer rp (each $clog2(DEPTH) bits, wrap modulo DEPTH), level counter, word index widx (2 bits).
- Push: res_valid && (level < DEPTH || pop) writes res_data at wp, and wp increments.
- Drop: res_valid && level == DEPTH && !pop; entry is discarded, overflow <= 1.
- Word transfer: out_valid && out_ready; widx increments and wraps 3 -> 0.
- Pop: word transfer while widx == 3; rp increments.
- level update: push && !pop +1; pop && !push -1; both or neither unchanged.
- out_valid = (level != 0).
- out_data = head[127-32*widx -: 32]: word 0 = bits 127:96, word 3 = bits 31:0.
- out_last = out_valid && widx == 3.
- Overflow precedence: a drop in the same cycle as clr_overflow leaves overflow = 1 (set wins).
- Serialization states, implied by widx: W0 -> W1 -> W2 -> W3 -> W0. Each step advances only on a word transfer and holds while out_ready is low.
- Handshake: out_data and out_last stay stable while out_valid && !out_ready. The sink may hold out_ready high continuously.
- Simultaneous push and pop when full: both take effect; level stays DEPTH; no drop.

## Timing
- Reset values: out_valid 0, out_last 0, level 0, overflow 0, widx 0, wp 0, rp 0. out_data is 0 only with zeroize enabled (see Configuration).
- Capture latency: res_valid at edge N gives out_valid = 1 and word 0 on out_data after edge N, i.e. in cycle N+1.
- Throughput: one word per cycle with out_ready held high. A block drains in 4 cycles, and the next block's word 0 follows with no bubble.
- out_valid, out_data and out_last are combinational from registered state; there is no combinational path from out_ready to out_valid.
- Reset mid-block: the partially sent block and all buffered blocks are discarded; the next block starts at word 0.
- Counter widths: level saturates by construction at DEPTH. Pointer wrap-around is natural modulo DEPTH.

## Configuration
- CRYPTO_DRAIN_ZEROIZE_EN defined:
  - on pop, the popped entry is written to 128'h0;
  - reset clears all entries;
  - out_data is forced to 32'h0 whenever out_valid is 0;
  - a push and pop to the same entry in one cycle: the push wins.
- Not defined:
  - entries retain stale data after pop and are not reset;
  - out_data always shows the head-entry mux, even when out_valid is 0.

## Test plan
- Single block: after reset, res_valid for 1 cycle with res_data = 128'h00112233_44556677_8899AABB_CCDDEEFF and out_ready = 1 -> out_data 00112233, 44556677, 8899AABB, CCDDEEFF on cycles N+1..N+4; out_last only on the 4th word; level returns to 0.
- Backpressure: same block with out_ready low for cycles N+1..N+3 -> out_data holds 00112233 and out_valid stays 1; sequence then resumes unchanged.
- Overflow: DEPTH=2, out_ready = 0, three strobes with blocks A, B, C -> level = 2, overflow = 1; the drain outputs A then B only; clr_overflow -> overflow 0.
- Full push+pop: level = 2, a strobe arrives in the same cycle as the word-3 transfer -> no drop, level stays 2, and the new block drains after the remaining block.
- Reset mid-block: reset asserted after word 1 -> out_valid 0, level 0. A new block then starts at word 0.
- Zeroize (macro on): after a full drain -> out_data = 0, and internal entries read 0 via hierarchical check. With the macro off, the same check shows stale data.
